mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one 4:1, WIDTH-bit data mux among four requesters. It sequences the mux select, issues one-hot grants, and registers the selected data with a valid strobe for the downstream consumer. It sits directly in front of the 4:1 mux datapath and owns its `sel` encoding.

## Interface
- `WIDTH`, default 4: data width per requester.
- `MAX_HOLD`, default 8: maximum grant length in cycles; used only when `ARB_HOLD_LIMIT_EN` is defined. Legal range 1..255.

- `clk`  in  1  rising-edge clock.
- `rstb`  in  1  reset, asynchronous, active-low.
- `req`  in  4  request per requester; held high for as long as the requester wants the mux.
- `data3`, `data2`, `data1`, `data0`  in  WIDTH each  requester data; `dataN` belongs to `req[N]`.
- `gnt`  out  4  one-hot grant, registered; all zero when idle.
- `sel`  out  2  mux select, registered; the encoding is `sel = 3 - granted index` (00→data3, 01→data2, 10→data1, 11→data0).
- `out`  out  WIDTH  registered selected data.
- `out_valid`  out  1  `out` holds data from a granted requester.

## Operation
- State machine has two states:
  - IDLE: `gnt = 0`.
  - GRANT: exactly one `gnt` bit is high.
- Round-robin pointer `ptr` (2 bits) names the highest-priority requester. Search order is `ptr`, `ptr+1`, … mod 4.
- IDLE → GRANT when any `req` bit is high at the edge. Grant the first requester in search order, load `sel`, and set `ptr = winner+1` mod 4.
- GRANT, granted `req` still high: hold the grant, `sel`, and `ptr`.
- GRANT, granted `req` low at the edge, other requests pending: hand off directly at the same edge to the next winner by search order, with no idle cycle. Update `ptr`.
- GRANT, granted `req` low, no other request pending: go to IDLE and clear `gnt`.
- Requests arriving while another requester holds the grant wait; they are never dropped.
- Datapath: on every edge, `out` ← data of the requester granted during that cycle, and `out_valid` ← (state was GRANT). `out` holds its value when `out_valid` is low.
- `sel` keeps its last value in IDLE.
- Reset values (asynchronous, immediate on `rstb` low): state IDLE, `gnt = 0000`, `sel = 00`, `ptr = 0`, `out = 0`, `out_valid = 0`, hold counter 0.
- Reset mid-grant aborts the transfer with no completion. After release, arbitration restarts from `ptr = 0`.

## Timing
- `req` high at edge N (IDLE) → `gnt`/`sel` valid after edge N.
- First `out`/`out_valid` after edge N+1: the data path lags the grant by one cycle.
- Release: `req[i]` low at edge M → `gnt[i]` low after edge M. `out_valid` for requester i drops after edge M+1 unless a handoff keeps it high with the new requester's data.
- Handoff: new `gnt`/`sel` after edge M. `out` switches source after edge M+1, so `out_valid` stays continuously high.
- Simultaneous requests are resolved purely by `ptr`. A single requester requesting continuously is never starved of its own grant.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined:
  - An 8-bit hold counter clears on each new grant and increments every GRANT cycle.
  - After `MAX_HOLD` grant cycles, the grant is revoked at that edge even if `req` is still high, and the request is treated as released.
  - The revoked requester is masked from arbitration for that edge.
  - If it is the only requester, it is re-granted after exactly one IDLE cycle.
- `ARB_HOLD_LIMIT_EN` undefined: no counter; a grant lasts until its `req` drops; `MAX_HOLD` is ignored.

## Test plan
- Reset: drive `rstb` low mid-grant → all outputs return to their reset values immediately. After release, `req = 1111` grants `gnt = 0001`, `sel = 11`.
- Single request: `req = 0100`, `data2 = 4'hA` → `gnt = 0100`, `sel = 01` one cycle later, `out = A` with `out_valid = 1` the cycle after that. Drop `req` → `gnt = 0` next cycle.
- Round robin: `req = 1111`, each requester drops `req` after 2 grant cycles and re-raises it one cycle later. Expect grant order 0,1,2,3,0 with direct handoffs and `out_valid` continuously high.
- Fairness after a non-zero pointer: grant 2 completes, then `req = 0011` → `gnt = 0001`, not `0010`, because search starts at requester 3 and then wraps to 0.
- Hold limit (`ARB_HOLD_LIMIT_EN`, `MAX_HOLD = 3`): `req = 0011` held high → `gnt` toggles 0001 and 0010 every 3 cycles. With `req = 0001` alone → 3 grant cycles, 1 idle cycle, repeating.
- Without the macro, same stimulus → `gnt = 0001` held indefinitely.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sequencing a shared 4:1 data mux with registered output.
// Optional grant length limit enabled by defining ARB_HOLD_LIMIT_EN.
`default_nettype none

module mux_rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data3,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data0,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       cur_idx;
  logic [WIDTH-1:0] cur_data;
  logic [3:0]       others;
  logic [2:0]       pick_idle;
  logic [2:0]       pick_hand;
  logic             released;

  // Returns {found, index} of the first set bit of mask searching from p upward, mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] p);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // sel encodes 3 - index, so the granted index is its bitwise inverse.
  assign cur_idx   = ~sel;
  assign others    = req & ~gnt;
  assign pick_idle = rr_pick(req, ptr);
  assign pick_hand = rr_pick(others, ptr);

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt;
  logic       hold_expired;
  assign hold_expired = (hold_cnt == 8'(MAX_HOLD - 1));
  assign released     = !req[cur_idx] || hold_expired;
`else
  assign released     = !req[cur_idx];
`endif

  always_comb begin
    cur_data = data0;
    case (cur_idx)
      2'd0: cur_data = data0;
      2'd1: cur_data = data1;
      2'd2: cur_data = data2;
      2'd3: cur_data = data3;
      default: cur_data = data0;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      sel       <= 2'b00;
      ptr       <= 2'd0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt  <= 8'd0;
`endif
    end else begin
      out_valid <= (state == GRANT);
      if (state == GRANT) out <= cur_data;

      case (state)
        IDLE: begin
          if (pick_idle[2]) begin
            state <= GRANT;
            gnt   <= 4'b0001 << pick_idle[1:0];
            sel   <= ~pick_idle[1:0];
            ptr   <= pick_idle[1:0] + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end
        GRANT: begin
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt <= hold_cnt + 8'd1;
`endif
          // The outgoing requester is excluded from `others`, so a revoked grant cannot re-win here.
          if (released) begin
            if (pick_hand[2]) begin
              gnt <= 4'b0001 << pick_hand[1:0];
              sel <= ~pick_hand[1:0];
              ptr <= pick_hand[1:0] + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
              hold_cnt <= 8'd0;
`endif
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and randomized checks of mux_rr_arbiter against a behavioural model.
`default_nettype none

module tb_mux_rr_arbiter;
  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 3;

  logic             clk = 1'b0;
  logic             rstb;
  logic [3:0]       req;
  logic [WIDTH-1:0] data3, data2, data1, data0;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  int errors = 0;
  int checks = 0;

  // Reference model: granted index (-1 when idle), priority pointer, completed grant cycles.
  int               m_g, m_ptr, m_gc;
  logic [3:0]       m_gnt;
  logic [1:0]       m_sel;
  logic [WIDTH-1:0] m_out;
  logic             m_valid;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rstb(rstb), .req(req),
    .data3(data3), .data2(data2), .data1(data1), .data0(data0),
    .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic int search(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_g = -1; m_ptr = 0; m_gc = 0;
    m_gnt = 4'b0; m_sel = 2'b0; m_out = '0; m_valid = 1'b0;
  endtask

  task automatic model_grant(input int w);
    m_g = w; m_ptr = (w + 1) % 4; m_gc = 0;
  endtask

  // Applies one rising edge to the model using the inputs present before that edge.
  task automatic model_edge();
    logic [WIDTH-1:0] d [4];
    logic [3:0] mask;
    int w;
    bit rel;
    d[0] = data0; d[1] = data1; d[2] = data2; d[3] = data3;
    m_valid = (m_g >= 0);
    if (m_g >= 0) m_out = d[m_g];
    if (m_g < 0) begin
      w = search(req, m_ptr);
      if (w >= 0) model_grant(w);
    end else begin
      m_gc++;
      rel = !req[m_g];
`ifdef ARB_HOLD_LIMIT_EN
      if (m_gc >= MAX_HOLD) rel = 1'b1;
`endif
      if (rel) begin
        mask = req;
        mask[m_g] = 1'b0;
        w = search(mask, m_ptr);
        if (w >= 0) model_grant(w);
        else m_g = -1;
      end
    end
    m_gnt = (m_g < 0) ? 4'b0 : 4'(1 << m_g);
    if (m_g >= 0) m_sel = 2'(3 - m_g);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rstb = 1'b0;
    req  = 4'b0;
    model_reset();
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    data1 = 4'h5;
    req = 4'b0010;
    tick();
    tick();
    #2;
    rstb = 1'b0;
    #1;
    model_reset();
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'b00 || out !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: gnt=%b sel=%b out=%h valid=%b, want 0000 00 0 0", gnt, sel, out, out_valid);
    end
    @(negedge clk);
    rstb = 1'b1;
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'b11) begin
      errors++;
      $display("FAIL reset_restart: gnt=%b sel=%b, want 0001 11", gnt, sel);
    end
  endtask

  task automatic test_single();
    apply_reset();
    data2 = 4'hA;
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'b01 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: gnt=%b sel=%b valid=%b, want 0100 01 0", gnt, sel, out_valid);
    end
    tick();
    checks++;
    if (out !== 4'hA || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_data: out=%h valid=%b, want a 1", out, out_valid);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_release: gnt=%b valid=%b, want 0000 1", gnt, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out !== 4'hA) begin
      errors++;
      $display("FAIL single_idle: valid=%b out=%h, want 0 a", out_valid, out);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int prev, hc;
    int want[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    data0 = 4'h1; data1 = 4'h2; data2 = 4'h3; data3 = 4'h4;
    req = 4'hF;
    prev = -1;
    hc = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (gnt !== m_gnt || sel !== m_sel || out !== m_out || out_valid !== m_valid) begin
        errors++;
        $display("FAIL rr_model c=%0d: gnt=%b sel=%b out=%h v=%b, want %b %b %h %b",
                 c, gnt, sel, out, out_valid, m_gnt, m_sel, m_out, m_valid);
      end
      if (c >= 1) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL rr_valid_gap c=%0d: valid=%b, want 1", c, out_valid);
        end
      end
      if (m_g >= 0 && m_g != prev) begin
        order.push_back(m_g);
        hc = 0;
      end
      prev = m_g;
      req = 4'hF;
      if (m_g >= 0) begin
        hc++;
        if (hc == 2) req[m_g] = 1'b0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= order.size() || order[i] != want[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, want %0d", i, (i < order.size()) ? order[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL fair_idle: gnt=%b, want 0000", gnt);
    end
    req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'b11) begin
      errors++;
      $display("FAIL fair_wrap: gnt=%b sel=%b, want 0001 11", gnt, sel);
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] exp;
    apply_reset();
    req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      tick();
`ifdef ARB_HOLD_LIMIT_EN
      exp = (((c / MAX_HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      exp = 4'b0001;
`endif
      checks++;
      if (gnt !== exp) begin
        errors++;
        $display("FAIL hold_pair c=%0d: gnt=%b, want %b", c, gnt, exp);
      end
    end
    apply_reset();
    req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
`ifdef ARB_HOLD_LIMIT_EN
      exp = ((c % (MAX_HOLD + 1)) < MAX_HOLD) ? 4'b0001 : 4'b0000;
`else
      exp = 4'b0001;
`endif
      checks++;
      if (gnt !== exp) begin
        errors++;
        $display("FAIL hold_single c=%0d: gnt=%b, want %b", c, gnt, exp);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      data0 = WIDTH'($urandom); data1 = WIDTH'($urandom);
      data2 = WIDTH'($urandom); data3 = WIDTH'($urandom);
      tick();
      checks++;
      if (gnt !== m_gnt || sel !== m_sel || out !== m_out || out_valid !== m_valid) begin
        errors++;
        $display("FAIL random c=%0d req=%b: gnt=%b sel=%b out=%h v=%b, want %b %b %h %b",
                 c, req, gnt, sel, out, out_valid, m_gnt, m_sel, m_out, m_valid);
      end
    end
  endtask

  initial begin
    rstb = 1'b0;
    req = 4'b0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    model_reset();
    #1;
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'b00 || out !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b sel=%b out=%h valid=%b, want 0000 00 0 0", gnt, sel, out, out_valid);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_hold_limit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
